// File: rtl/serializer_arbiter.sv
// serializer_arbiter
// Shares a single serializer between NUM_REQ parallel-word requesters using
// round-robin arbitration. The winning word is latched and presented to the
// serializer with a start/busy handshake. Completion is reported to the
// owning requester, and an idle gap is then enforced on the serial line.
//
// Ports:
//   clock      system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   req        level request per requester; its word is valid while high
//   req_data   requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   ack        one-cycle one-hot pulse: requester word latched
//   done       one-cycle one-hot pulse: requester frame fully shifted out
//   error      one-cycle pulse: serializer never started, frame dropped
//   active_id  index of the requester currently owning the serializer
//   busy       high whenever the controller is not idle
//   ser_start  start strobe to the serializer
//   ser_data   word to the serializer, held from launch until the next grant
//   ser_busy   busy flag from the serializer
module serializer_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int GAP_CYCLES    = 1,
    parameter int START_TIMEOUT = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          error,
    output logic [$clog2(NUM_REQ)-1:0]    active_id,
    output logic                          busy,
    output logic                          ser_start,
    output logic [DATA_WIDTH-1:0]         ser_data,
    input  logic                          ser_busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(START_TIMEOUT);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        GAP
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  last;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    int               scan_idx;

    // Round-robin pick: the first requester found scanning from the one
    // after the previous winner, wrapping around, so the previous winner
    // comes last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_idx = (int'(last) + off) % NUM_REQ;
            if (!grant_valid && req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(scan_idx);
            end
        end
    end

    // Controller FSM. Every output is a register. The ack, done and error
    // pulses default low and are raised for a single cycle on their
    // transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ack       <= '0;
            done      <= '0;
            error     <= 1'b0;
            ser_start <= 1'b0;
            ser_data  <= '0;
            active_id <= '0;
            busy      <= 1'b0;
            last      <= LAST_INIT;
            to_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            ack   <= '0;
            done  <= '0;
            error <= 1'b0;
            case (state)
                // A serializer still draining a frame from before a reset
                // must finish before the line can be handed out again.
                IDLE: begin
                    if (!ser_busy && grant_valid) begin
                        ser_data  <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
                        active_id <= grant_id;
                        last      <= grant_id;
                        ack       <= NUM_REQ'(1) << grant_id;
                        ser_start <= 1'b1;
                        busy      <= 1'b1;
                        to_cnt    <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (ser_busy) begin
                        ser_start <= 1'b0;
                        state     <= RUN;
                    end else if (to_cnt == TO_LAST) begin
                        ser_start <= 1'b0;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!ser_busy) begin
                        done <= NUM_REQ'(1) << active_id;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
